// File: rtl/imm_pkg.sv
// Shared types and constants for the immediate-extension stage.
package imm_pkg;

    localparam int IMM_W = 25;
    localparam int PFX_W = 19;

    // 3-bit format code carried with each decoded instruction; 6 and 7 are unnamed
    typedef enum logic [2:0] {
        FMT_I   = 3'd0,
        FMT_U   = 3'd1,
        FMT_S   = 3'd2,
        FMT_B   = 3'd3,
        FMT_J   = 3'd4,
        FMT_PFX = 3'd5
    } imm_fmt_e;

    // Prefix-fusion state
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_HELD = 1'b1
    } pfx_state_e;

endpackage

// File: rtl/imm_ext_comb.sv
// Combinational format table: raw 25-bit immediate field to 32-bit imm/imm2.
module imm_ext_comb
    import imm_pkg::*;
(
    input  logic [IMM_W-1:0] imm_i,
    input  logic [2:0]       fmt_i,
    output logic [31:0]      imm_o,
    output logic [31:0]      imm2_o
);

    // Decode the format code; imm2 is only meaningful for FMT_B
    always_comb begin
        imm_o  = '0;
        imm2_o = '0;
        case (fmt_i)
            FMT_I: imm_o = {{19{imm_i[24]}}, imm_i[24:12]};
            FMT_U: imm_o = {imm_i[24:6], 13'b0};
            FMT_S: imm_o = {{19{imm_i[24]}}, imm_i[24:18], imm_i[5:0]};
            FMT_B: begin
                imm_o  = {{26{imm_i[17]}}, imm_i[17:12]};
                imm2_o = {{19{imm_i[24]}}, imm_i[24:18], imm_i[5:0]};
            end
            FMT_J: imm_o = {{13{imm_i[24]}}, imm_i[24:6]};
            default: begin
                imm_o  = '0;
                imm2_o = '0;
            end
        endcase
    end

endmodule

// File: rtl/imm_ext_stage.sv
// Registered, handshaked immediate-extension stage with prefix fusion.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | no prefix outstanding; every non-prefix input is extended
//  ST_HELD | pfx_q holds the upper 19 bits waiting for a format-0 partner
module imm_ext_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int TAG_W = 8
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IMM_W-1:0] in_imm,
    input  logic [2:0]       in_src,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_imm,
    output logic [XLEN-1:0]  out_imm2,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_fused,
    output logic             prefix_err
);

    pfx_state_e       state_q, state_d;
    logic [PFX_W-1:0] pfx_q, pfx_d;
    logic             valid_q, valid_d;
    logic [XLEN-1:0]  imm_q, imm_d;
    logic [XLEN-1:0]  imm2_q, imm2_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             fused_q, fused_d;
    logic             perr_q, perr_d;

    logic [31:0]      ext_imm;
    logic [31:0]      ext_imm2;
    logic [31:0]      fused_imm;
    logic             accept;

    // Every 32-bit result widens by replicating its bit 31, format U included
    function automatic logic [XLEN-1:0] sext_xlen(input logic [31:0] v);
        logic [XLEN-1:0] r;
        r       = {XLEN{v[31]}};
        r[31:0] = v;
        return r;
    endfunction

    imm_ext_comb u_comb (
        .imm_i  (in_imm),
        .fmt_i  (in_src),
        .imm_o  (ext_imm),
        .imm2_o (ext_imm2)
    );

    assign fused_imm = {pfx_q, in_imm[24:12]};
    // Single output register: accept when it is empty or draining; flush blocks intake
    assign in_ready  = !flush && (!valid_q || out_ready);
    assign accept    = in_valid && in_ready;

    // Next-state: FSM, prefix capture, output beat and prefix-error pulse
    always_comb begin
        state_d = state_q;
        pfx_d   = pfx_q;
        valid_d = valid_q;
        imm_d   = imm_q;
        imm2_d  = imm2_q;
        tag_d   = tag_q;
        fused_d = fused_q;
        perr_d  = 1'b0;
        if (flush) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
        end else if (accept) begin
            if (in_src == FMT_PFX) begin
                // A prefix produces no beat; any older beat is draining this cycle
                state_d = ST_HELD;
                pfx_d   = in_imm[24:6];
                valid_d = 1'b0;
                perr_d  = (state_q == ST_HELD);
            end else begin
                state_d = ST_IDLE;
                valid_d = 1'b1;
                tag_d   = in_tag;
                imm2_d  = sext_xlen(ext_imm2);
                if (state_q == ST_HELD && in_src == FMT_I) begin
                    imm_d   = sext_xlen(fused_imm);
                    fused_d = 1'b1;
                end else begin
                    imm_d   = sext_xlen(ext_imm);
                    fused_d = 1'b0;
                end
                perr_d = (state_q == ST_HELD) && (in_src != FMT_I);
            end
        end else if (out_ready) begin
            valid_d = 1'b0;
        end
    end

    // State and output registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            pfx_q   <= '0;
            valid_q <= 1'b0;
            imm_q   <= '0;
            imm2_q  <= '0;
            tag_q   <= '0;
            fused_q <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pfx_q   <= pfx_d;
            valid_q <= valid_d;
            imm_q   <= imm_d;
            imm2_q  <= imm2_d;
            tag_q   <= tag_d;
            fused_q <= fused_d;
            perr_q  <= perr_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_imm    = imm_q;
    assign out_imm2   = imm2_q;
    assign out_tag    = tag_q;
    assign out_fused  = fused_q;
    assign prefix_err = perr_q;

endmodule

// File: tb/tb_imm_ext_stage.sv
// Bench for imm_ext_stage: directed scenarios plus a randomized run against a reference model.
module tb_imm_ext_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        flush;
    logic        in_valid;
    logic [24:0] in_imm;
    logic [2:0]  in_src;
    logic [7:0]  in_tag;
    logic        out_ready;

    logic        in_ready, out_valid, out_fused, prefix_err;
    logic [31:0] out_imm, out_imm2;
    logic [7:0]  out_tag;

    logic        in_ready64, out_valid64, out_fused64, prefix_err64;
    logic [63:0] out_imm64, out_imm2_64;
    logic [7:0]  out_tag64;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    imm_ext_stage #(.XLEN(32), .TAG_W(8)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_src(in_src), .in_tag(in_tag), .out_valid(out_valid),
        .out_ready(out_ready), .out_imm(out_imm), .out_imm2(out_imm2), .out_tag(out_tag),
        .out_fused(out_fused), .prefix_err(prefix_err)
    );

    imm_ext_stage #(.XLEN(64), .TAG_W(8)) dut64 (
        .clk(clk), .rstn(rstn), .flush(flush), .in_valid(in_valid), .in_ready(in_ready64),
        .in_imm(in_imm), .in_src(in_src), .in_tag(in_tag), .out_valid(out_valid64),
        .out_ready(out_ready), .out_imm(out_imm64), .out_imm2(out_imm2_64), .out_tag(out_tag64),
        .out_fused(out_fused64), .prefix_err(prefix_err64)
    );

    // ---------------- reference model (arithmetic on field values) ----------------
    function automatic logic [31:0] sx(input longint v, input int n);
        longint x;
        x = v;
        if (x >= (longint'(1) << (n - 1))) x = x - (longint'(1) << n);
        return x[31:0];
    endfunction

    function automatic logic [31:0] ref_imm(input int f, input longint imm);
        longint t;
        case (f)
            0: return sx(imm >> 12, 13);
            1: begin t = (imm >> 6) << 13; return t[31:0]; end
            2: return sx(((imm >> 18) << 6) + (imm % 64), 13);
            3: return sx((imm >> 12) % 64, 6);
            4: return sx(imm >> 6, 19);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic [31:0] ref_imm2(input int f, input longint imm);
        if (f == 3) return sx(((imm >> 18) << 6) + (imm % 64), 13);
        return 32'h0;
    endfunction

    function automatic logic [31:0] ref_fused(input longint pfx, input longint imm);
        longint t;
        t = (pfx << 13) + (imm >> 12);
        return t[31:0];
    endfunction

    function automatic logic [63:0] widen(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // ---------------- drive helpers (no checking) ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] src, input logic [24:0] imm, input logic [7:0] tag);
        in_valid = 1'b1;
        in_src   = src;
        in_imm   = imm;
        in_tag   = tag;
    endtask

    task automatic idle();
        in_valid = 1'b0;
        in_src   = 3'd0;
        in_imm   = '0;
        in_tag   = '0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        idle();
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        total++; if (out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", out_valid); else passed++;
        total++; if (out_imm !== 32'h0 || out_imm2 !== 32'h0) $display("FAIL reset_imm: got %h/%h want 0/0", out_imm, out_imm2); else passed++;
        total++; if (out_tag !== 8'h0 || out_fused !== 1'b0 || prefix_err !== 1'b0) $display("FAIL reset_misc: tag %h fused %b perr %b want 0", out_tag, out_fused, prefix_err); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_ready: got %b want 1", in_ready); else passed++;
    endtask

    task automatic test_fmt0_sext();
        drive(3'd0, 25'h1FFF000, 8'h11);
        tick();
        idle();
        total++; if (out_valid !== 1'b1) $display("FAIL fmt0_valid: got %b want 1", out_valid); else passed++;
        total++; if (out_imm !== 32'hFFFFFFFF) $display("FAIL fmt0_imm: got %h want ffffffff", out_imm); else passed++;
        total++; if (out_imm2 !== 32'h0 || out_fused !== 1'b0 || out_tag !== 8'h11) $display("FAIL fmt0_misc: imm2 %h fused %b tag %h want 0/0/11", out_imm2, out_fused, out_tag); else passed++;
        total++; if (out_imm64 !== 64'hFFFFFFFFFFFFFFFF) $display("FAIL fmt0_imm64: got %h want all ones", out_imm64); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL fmt0_drain: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_fusion();
        drive(3'd5, {19'h12345, 6'h0}, 8'h3);
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL fuse_nobeat: got %b want 0", out_valid); else passed++;
        drive(3'd0, {13'h0ABC, 12'h0}, 8'h7);
        tick();
        idle();
        total++; if (out_valid !== 1'b1 || out_imm !== 32'h2468AABC) $display("FAIL fuse_imm: valid %b imm %h want 1/2468aabc", out_valid, out_imm); else passed++;
        total++; if (out_fused !== 1'b1 || out_tag !== 8'h7 || prefix_err !== 1'b0) $display("FAIL fuse_flags: fused %b tag %h perr %b want 1/07/0", out_fused, out_tag, prefix_err); else passed++;
        total++; if (out_imm64 !== 64'h000000002468AABC) $display("FAIL fuse_imm64: got %h want 2468aabc", out_imm64); else passed++;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL fuse_single_beat: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_fmt1_xlen64();
        drive(3'd1, {19'h40000, 6'h0}, 8'h21);
        tick();
        idle();
        total++; if (out_imm !== 32'h80000000) $display("FAIL fmt1_imm: got %h want 80000000", out_imm); else passed++;
        total++; if (out_imm64 !== 64'hFFFFFFFF80000000) $display("FAIL fmt1_imm64: got %h want ffffffff80000000", out_imm64); else passed++;
        tick();
    endtask

    task automatic test_fmt3_stall();
        drive(3'd3, 25'h1FC003F, 8'h33);
        tick();
        out_ready = 1'b0;
        drive(3'd0, 25'h0001000, 8'h99);
        total++; if (out_imm !== 32'h0 || out_imm2 !== 32'hFFFFFFFF) $display("FAIL fmt3_imm: got %h/%h want 0/ffffffff", out_imm, out_imm2); else passed++;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (out_valid !== 1'b1 || out_imm !== 32'h0 || out_imm2 !== 32'hFFFFFFFF || out_tag !== 8'h33 || in_ready !== 1'b0)
                $display("FAIL stall_hold: cyc %0d valid %b imm %h imm2 %h tag %h ready %b", i, out_valid, out_imm, out_imm2, out_tag, in_ready);
            else passed++;
        end
        idle();
        out_ready = 1'b1;
        tick();
        total++; if (out_valid !== 1'b0) $display("FAIL stall_release: got %b want 0", out_valid); else passed++;
    endtask

    task automatic test_prefix_err();
        drive(3'd5, {19'h00007, 6'h0}, 8'h1);
        tick();
        drive(3'd2, 25'h1FC003F, 8'h9);
        tick();
        idle();
        total++; if (prefix_err !== 1'b1) $display("FAIL perr_pulse: got %b want 1", prefix_err); else passed++;
        total++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_fused !== 1'b0 || out_imm2 !== 32'h0 || out_tag !== 8'h9)
            $display("FAIL perr_result: valid %b imm %h fused %b imm2 %h tag %h", out_valid, out_imm, out_fused, out_imm2, out_tag); else passed++;
        tick();
        total++; if (prefix_err !== 1'b0) $display("FAIL perr_once: got %b want 0", prefix_err); else passed++;
        drive(3'd0, {13'h0005, 12'h0}, 8'h2);
        tick();
        idle();
        total++; if (out_imm !== 32'h5 || out_fused !== 1'b0) $display("FAIL perr_idle: imm %h fused %b want 5/0", out_imm, out_fused); else passed++;
        drive(3'd5, {19'h00010, 6'h0}, 8'h1);
        tick();
        drive(3'd5, {19'h00001, 6'h0}, 8'h1);
        tick();
        total++; if (prefix_err !== 1'b1 || out_valid !== 1'b0) $display("FAIL perr_replace: perr %b valid %b want 1/0", prefix_err, out_valid); else passed++;
        drive(3'd0, {13'h0002, 12'h0}, 8'h4);
        tick();
        idle();
        total++; if (out_imm !== 32'h00002002 || out_fused !== 1'b1 || prefix_err !== 1'b0) $display("FAIL perr_refused: imm %h fused %b perr %b want 2002/1/0", out_imm, out_fused, prefix_err); else passed++;
        tick();
    endtask

    task automatic test_flush();
        drive(3'd5, {19'h12345, 6'h0}, 8'h1);
        tick();
        flush = 1'b1;
        drive(3'd0, {13'h0ABC, 12'h0}, 8'h44);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL flush_ready: got %b want 0", in_ready); else passed++;
        tick();
        flush = 1'b0;
        idle();
        total++; if (out_valid !== 1'b0 || prefix_err !== 1'b0) $display("FAIL flush_drop: valid %b perr %b want 0/0", out_valid, prefix_err); else passed++;
        drive(3'd0, {13'h0001, 12'h0}, 8'h45);
        tick();
        idle();
        total++; if (out_valid !== 1'b1 || out_imm !== 32'h1 || out_fused !== 1'b0 || prefix_err !== 1'b0)
            $display("FAIL flush_after: valid %b imm %h fused %b perr %b want 1/1/0/0", out_valid, out_imm, out_fused, prefix_err); else passed++;
        tick();
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        drive(3'd4, 25'h1ABCDEF, 8'h5A);
        tick();
        idle();
        #2 rstn = 1'b0;
        #1;
        total++; if (out_valid !== 1'b0 || out_imm !== 32'h0 || out_imm2 !== 32'h0 || out_tag !== 8'h0 || out_fused !== 1'b0 || prefix_err !== 1'b0)
            $display("FAIL areset_beat: valid %b imm %h imm2 %h tag %h fused %b perr %b", out_valid, out_imm, out_imm2, out_tag, out_fused, prefix_err); else passed++;
        @(posedge clk);
        #1 rstn = 1'b1;
        out_ready = 1'b1;
        drive(3'd5, {19'h7FFFF, 6'h0}, 8'h1);
        tick();
        idle();
        #2 rstn = 1'b0;
        #2 rstn = 1'b1;
        drive(3'd0, {13'h1FFF, 12'h0}, 8'h6);
        tick();
        idle();
        total++; if (out_valid !== 1'b1 || out_imm !== 32'hFFFFFFFF || out_fused !== 1'b0)
            $display("FAIL areset_prefix: valid %b imm %h fused %b want 1/ffffffff/0", out_valid, out_imm, out_fused); else passed++;
        tick();
    endtask

    task automatic test_random();
        bit          m_ov, m_held, m_perr, exp_ready;
        logic [31:0] m_imm, m_imm2;
        logic [7:0]  m_tag;
        bit          m_fused;
        longint      m_pfx, im;
        int          f;
        do_reset();
        m_ov = 0; m_held = 0; m_perr = 0; m_pfx = 0;
        m_imm = '0; m_imm2 = '0; m_tag = '0; m_fused = 0;
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 4) != 0;
            flush     = ($urandom % 20) == 0;
            in_src    = ($urandom % 3 == 0) ? 3'd5 : (($urandom % 2 == 0) ? 3'd0 : 3'($urandom % 8));
            in_imm    = 25'($urandom);
            in_tag    = 8'($urandom);
            #1;
            exp_ready = !flush && (!m_ov || out_ready);
            total++; if (in_ready !== exp_ready || in_ready64 !== exp_ready) $display("FAIL rnd_ready: cyc %0d got %b/%b want %b", c, in_ready, in_ready64, exp_ready); else passed++;
            f  = int'(in_src);
            im = longint'(in_imm);
            m_perr = 0;
            if (flush) begin
                m_ov = 0;
                m_held = 0;
            end else if (in_valid && exp_ready) begin
                if (f == 5) begin
                    m_perr = m_held;
                    m_held = 1;
                    m_pfx  = im >> 6;
                    m_ov   = 0;
                end else begin
                    m_perr  = m_held && (f != 0);
                    m_fused = m_held && (f == 0);
                    m_imm   = m_fused ? ref_fused(m_pfx, im) : ref_imm(f, im);
                    m_imm2  = ref_imm2(f, im);
                    m_tag   = in_tag;
                    m_ov    = 1;
                    m_held  = 0;
                end
            end else if (out_ready) begin
                m_ov = 0;
            end
            tick();
            total++; if (out_valid !== m_ov || prefix_err !== m_perr) $display("FAIL rnd_ctrl: cyc %0d valid %b perr %b want %b %b", c, out_valid, prefix_err, m_ov, m_perr); else passed++;
            if (m_ov) begin
                total++;
                if (out_imm !== m_imm || out_imm2 !== m_imm2 || out_tag !== m_tag || out_fused !== m_fused || out_imm64 !== widen(m_imm) || out_imm2_64 !== widen(m_imm2))
                    $display("FAIL rnd_data: cyc %0d imm %h imm2 %h tag %h fused %b imm64 %h want %h %h %h %b", c, out_imm, out_imm2, out_tag, out_fused, out_imm64, m_imm, m_imm2, m_tag, m_fused);
                else passed++;
            end
        end
        flush = 1'b0;
        out_ready = 1'b1;
        idle();
    endtask

    initial begin
        rstn = 1'b0;
        flush = 1'b0;
        out_ready = 1'b1;
        idle();
        test_reset();
        test_fmt0_sext();
        test_fusion();
        test_fmt1_xlen64();
        test_fmt3_stall();
        test_prefix_err();
        test_flush();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
